dtw_result_filter: RTL and testbench

Downstream stage of the DTW core. Consumes the core's serialized 3-word result stream (query id, best-match position, minimum cost) from the sink FIFO's read side as an AXI-Stream slave. Compares cost against a software threshold, tags each record match/non-match, optionally drops non-matches, and re-emits framed 3-word records on an AXI-Stream master toward the DMA. Keeps running record and match counters for software.

---
 rtl/dtw_pkg.sv | 17 +
 rtl/dtw_result_stats.sv | 33 +++
 rtl/dtw_result_filter.sv | 140 ++++++++++++++
 tb/tb_dtw_result_filter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW result path: FSM states, record word indices
// and the position of the match flag in the emitted cost word.
package dtw_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DECIDE  = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [1:0] IDX_QID  = 2'd0;
  localparam logic [1:0] IDX_POS  = 2'd1;
  localparam logic [1:0] IDX_COST = 2'd2;

  localparam int MATCH_BIT = 31;

endpackage

// File: rtl/dtw_result_stats.sv
// Record / match statistics counters for the result filter.
// A clear in the same cycle as a decision wins; that record is not counted.
module dtw_result_stats #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 decide_i,
  input  logic                 match_i,
  output logic [CNT_WIDTH-1:0] rec_count_o,
  output logic [CNT_WIDTH-1:0] match_count_o
);

  logic [CNT_WIDTH-1:0] rec_q, match_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_q   <= '0;
      match_q <= '0;
    end else if (clear_i) begin
      rec_q   <= '0;
      match_q <= '0;
    end else if (decide_i) begin
      rec_q <= rec_q + 1'b1;
      if (match_i) match_q <= match_q + 1'b1;
    end
  end

  assign rec_count_o   = rec_q;
  assign match_count_o = match_q;

endmodule

// File: rtl/dtw_result_filter.sv
// Threshold filter for DTW results: collects 3-word records, tags match/non-match
// against the software threshold, optionally drops non-matches, re-emits framed records.
module dtw_result_filter
  import dtw_pkg::*;
#(
  parameter int AXIS_WIDTH = 32,
  parameter int WIDTH      = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      threshold,
  input  logic                  drop_nonmatch,
  input  logic                  clear_stats,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rec_count,
  output logic [CNT_WIDTH-1:0]  match_count
);

  state_t                state_q;
  logic [1:0]            idx_q;
  logic [AXIS_WIDTH-1:0] qid_q, pos_q;
  logic [WIDTH-1:0]      cost_q;
  logic                  match_q;
  logic                  s_rdy_q;
  logic                  m_valid_q, m_last_q;
  logic [AXIS_WIDTH-1:0] m_data_q;

  logic                  match_w;
  logic                  decide_w;
  logic [AXIS_WIDTH-1:0] cost_word_w;

  assign match_w  = (cost_q < threshold);
  assign decide_w = (state_q == DECIDE);

  always_comb begin
    cost_word_w            = '0;
    cost_word_w[WIDTH-1:0] = cost_q;
    cost_word_w[MATCH_BIT] = match_q;
  end

  // idx_q counts input words in COLLECT and output words in EMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COLLECT;
      idx_q     <= IDX_QID;
      qid_q     <= '0;
      pos_q     <= '0;
      cost_q    <= '0;
      match_q   <= 1'b0;
      s_rdy_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          s_rdy_q <= 1'b1;
          if (s_rdy_q && s_axis_tvalid) begin
            case (idx_q)
              IDX_QID: qid_q  <= s_axis_tdata;
              IDX_POS: pos_q  <= s_axis_tdata;
              default: cost_q <= s_axis_tdata[WIDTH-1:0];
            endcase
            if (idx_q == IDX_COST) begin
              state_q <= DECIDE;
              idx_q   <= IDX_QID;
              s_rdy_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        DECIDE: begin
          match_q <= match_w;
          if (match_w || !drop_nonmatch) begin
            state_q   <= EMIT;
            idx_q     <= IDX_QID;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            m_data_q  <= qid_q;
          end else begin
            state_q <= COLLECT;
            s_rdy_q <= 1'b1;
          end
        end
        EMIT: begin
          if (m_axis_tready) begin
            case (idx_q)
              IDX_QID: begin
                idx_q    <= IDX_POS;
                m_data_q <= pos_q;
              end
              IDX_POS: begin
                idx_q    <= IDX_COST;
                m_data_q <= cost_word_w;
                m_last_q <= 1'b1;
              end
              default: begin
                idx_q     <= IDX_QID;
                state_q   <= COLLECT;
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                s_rdy_q   <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          state_q <= COLLECT;
          idx_q   <= IDX_QID;
        end
      endcase
    end
  end

  dtw_result_stats #(.CNT_WIDTH(CNT_WIDTH)) u_stats (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear_stats),
    .decide_i      (decide_w),
    .match_i       (match_w),
    .rec_count_o   (rec_count),
    .match_count_o (match_count)
  );

  assign s_axis_tready = s_rdy_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdata  = m_data_q;
  assign busy          = !((state_q == COLLECT) && (idx_q == IDX_QID));

endmodule

// File: tb/tb_dtw_result_filter.sv
// Directed bench for dtw_result_filter: hand-computed records, timing, backpressure,
// clear collision and asynchronous reset.
module tb_dtw_result_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] threshold = '0;
  logic        drop_nonmatch = 1'b0;
  logic        clear_stats = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        busy;
  logic [31:0] rec_count, match_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dtw_result_filter dut (
    .clk           (clk),
    .rst           (rst),
    .threshold     (threshold),
    .drop_nonmatch (drop_nonmatch),
    .clear_stats   (clear_stats),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .rec_count     (rec_count),
    .match_count   (match_count)
  );

  // Input word: presented at a falling edge, held until accepted at a rising edge.
  task automatic send_word(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
  endtask

  // Output word: ready is raised only for the cycle in which the word is taken.
  task automatic recv_word(output logic [31:0] d, output logic l, output bit ok);
    ok = 1'b0;
    d  = '0;
    l  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin
        d = m_axis_tdata;
        l = m_axis_tlast;
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_record(input logic [31:0] w0, w1, w2, output bit ok);
    bit a, b, c;
    send_word(w0, a);
    send_word(w1, b);
    send_word(w2, c);
    ok = a & b & c;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready got %b want 0", s_axis_tready); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_m_last got %b want 0", m_axis_tlast); end
    n_cmp++; if (m_axis_tdata !== 32'h0) begin n_err++; $display("FAIL reset_m_data got %h want 0", m_axis_tdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (rec_count !== 32'h0 || match_count !== 32'h0) begin n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", rec_count, match_count); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL reset_release_s_ready got %b want 1", s_axis_tready); end
  endtask

  task automatic test_basic_match();
    bit ok;
    logic [31:0] d;
    logic l;
    threshold = 16'h0100;
    drop_nonmatch = 1'b0;
    send_record(32'h0000_0007, 32'h0000_1234, 32'h0000_0050, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_input_accept got timeout want accept"); end
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || s_axis_tready !== 1'b0) begin n_err++; $display("FAIL basic_decide_cycle got valid=%b busy=%b rdy=%b want 0 1 0", m_axis_tvalid, busy, s_axis_tready); end
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0000_0007) begin n_err++; $display("FAIL basic_latency got valid=%b data=%h want 1 00000007", m_axis_tvalid, m_axis_tdata); end
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0007 || l !== 1'b0) begin n_err++; $display("FAIL basic_word0 got %h last=%b want 00000007 last=0", d, l); end
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL basic_no_overlap got %b want 0", s_axis_tready); end
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_1234 || l !== 1'b0) begin n_err++; $display("FAIL basic_word1 got %h last=%b want 00001234 last=0", d, l); end
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h8000_0050 || l !== 1'b1) begin n_err++; $display("FAIL basic_word2 got %h last=%b want 80000050 last=1", d, l); end
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin n_err++; $display("FAIL basic_return got valid=%b rdy=%b want 0 1", m_axis_tvalid, s_axis_tready); end
    n_cmp++; if (rec_count !== 32'd1 || match_count !== 32'd1) begin n_err++; $display("FAIL basic_counts got %0d/%0d want 1/1", rec_count, match_count); end
  endtask

  task automatic test_boundary_drop();
    bit ok;
    logic [31:0] d;
    logic l;
    threshold = 16'h0050;
    drop_nonmatch = 1'b0;
    send_record(32'h0000_0011, 32'h0000_0022, 32'hFFFF_0050, ok);
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0011) begin n_err++; $display("FAIL bound_word0 got %h want 00000011", d); end
    recv_word(d, l, ok);
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0050 || l !== 1'b1) begin n_err++; $display("FAIL bound_word2 got %h last=%b want 00000050 last=1", d, l); end
    n_cmp++; if (rec_count !== 32'd2 || match_count !== 32'd1) begin n_err++; $display("FAIL bound_counts got %0d/%0d want 2/1", rec_count, match_count); end
    drop_nonmatch = 1'b1;
    send_record(32'h0000_0011, 32'h0000_0022, 32'h0000_0050, ok);
    @(negedge clk);
    n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL drop_decide_rdy got %b want 0", s_axis_tready); end
    @(negedge clk);
    n_cmp++; if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL drop_return got rdy=%b valid=%b busy=%b want 1 0 0", s_axis_tready, m_axis_tvalid, busy); end
    n_cmp++; if (rec_count !== 32'd3 || match_count !== 32'd1) begin n_err++; $display("FAIL drop_counts got %0d/%0d want 3/1", rec_count, match_count); end
    drop_nonmatch = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int stall_bad;
    int hs;
    logic [31:0] exp_d [3];
    logic        exp_l [3];
    exp_d[0] = 32'h0000_000A; exp_d[1] = 32'h0000_000B; exp_d[2] = 32'h8000_0010;
    exp_l[0] = 1'b0;          exp_l[1] = 1'b0;          exp_l[2] = 1'b1;
    threshold = 16'h0100;
    send_record(32'h0000_000A, 32'h0000_000B, 32'h0000_0010, ok);
    hs = 0;
    for (int w = 0; w < 3; w++) begin
      stall_bad = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (c >= 1 || w > 0) begin
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[w] || m_axis_tlast !== exp_l[w] || s_axis_tready !== 1'b0)
            stall_bad++;
        end
      end
      n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL bp_stall_w%0d got %0d unstable cycles (data=%h last=%b) want 0 (data=%h last=%b)", w, stall_bad, m_axis_tdata, m_axis_tlast, exp_d[w], exp_l[w]); end
      m_axis_tready = 1'b1;
      @(posedge clk);
      if (m_axis_tvalid) hs++;
      #1;
      m_axis_tready = 1'b0;
    end
    m_axis_tready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      if (m_axis_tvalid) hs++;
    end
    #1;
    m_axis_tready = 1'b0;
    n_cmp++; if (hs != 3) begin n_err++; $display("FAIL bp_handshakes got %0d want 3", hs); end
    n_cmp++; if (rec_count !== 32'd4 || match_count !== 32'd2) begin n_err++; $display("FAIL bp_counts got %0d/%0d want 4/2", rec_count, match_count); end
  endtask

  task automatic test_sparse();
    bit ok;
    int bad;
    logic [31:0] d;
    logic l;
    threshold = 16'h0100;
    send_word(32'h0000_0033, ok);
    send_word(32'h0000_0044, ok);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || s_axis_tready !== 1'b1 || rec_count !== 32'd4) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL sparse_idle got %0d bad cycles want 0", bad); end
    send_word(32'h0000_0200, ok);
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0033) begin n_err++; $display("FAIL sparse_word0 got %h want 00000033", d); end
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0044) begin n_err++; $display("FAIL sparse_word1 got %h want 00000044", d); end
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0200 || l !== 1'b1) begin n_err++; $display("FAIL sparse_word2 got %h last=%b want 00000200 last=1", d, l); end
    n_cmp++; if (rec_count !== 32'd5 || match_count !== 32'd2) begin n_err++; $display("FAIL sparse_counts got %0d/%0d want 5/2", rec_count, match_count); end
  endtask

  task automatic test_clear_collision();
    bit ok;
    logic [31:0] d;
    logic l;
    threshold = 16'h0100;
    @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    n_cmp++; if (rec_count !== 32'd0 || match_count !== 32'd0) begin n_err++; $display("FAIL clear_plain got %0d/%0d want 0/0", rec_count, match_count); end
    for (int r = 0; r < 5; r++) begin
      send_record(32'h100 + r, 32'h200 + r, 32'h0000_0020, ok);
      recv_word(d, l, ok);
      recv_word(d, l, ok);
      recv_word(d, l, ok);
    end
    n_cmp++; if (rec_count !== 32'd5 || match_count !== 32'd5) begin n_err++; $display("FAIL clear_pre_counts got %0d/%0d want 5/5", rec_count, match_count); end
    send_record(32'h0000_0055, 32'h0000_0066, 32'h0000_0020, ok);
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0055) begin n_err++; $display("FAIL clear_word0 got %h want 00000055", d); end
    recv_word(d, l, ok);
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h8000_0020 || l !== 1'b1) begin n_err++; $display("FAIL clear_word2 got %h last=%b want 80000020 last=1", d, l); end
    n_cmp++; if (rec_count !== 32'd0 || match_count !== 32'd0) begin n_err++; $display("FAIL clear_collision got %0d/%0d want 0/0", rec_count, match_count); end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [31:0] d;
    logic l;
    threshold = 16'h0100;
    send_record(32'h0000_0077, 32'h0000_0088, 32'h0000_0030, ok);
    recv_word(d, l, ok);
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0000_0088 || rec_count !== 32'd1) begin n_err++; $display("FAIL areset_pre got valid=%b data=%h rec=%0d want 1 00000088 1", m_axis_tvalid, m_axis_tdata, rec_count); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL areset_outputs got valid=%b last=%b busy=%b want 0 0 0", m_axis_tvalid, m_axis_tlast, busy); end
    n_cmp++; if (rec_count !== 32'd0 || match_count !== 32'd0 || s_axis_tready !== 1'b0) begin n_err++; $display("FAIL areset_state got %0d/%0d rdy=%b want 0/0 rdy=0", rec_count, match_count, s_axis_tready); end
    @(negedge clk);
    rst = 1'b1;
    send_record(32'h0000_0099, 32'h0000_00AA, 32'h0000_0120, ok);
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0099 || l !== 1'b0) begin n_err++; $display("FAIL areset_next_word0 got %h last=%b want 00000099 last=0", d, l); end
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_00AA) begin n_err++; $display("FAIL areset_next_word1 got %h want 000000aa", d); end
    recv_word(d, l, ok);
    n_cmp++; if (!ok || d !== 32'h0000_0120 || l !== 1'b1) begin n_err++; $display("FAIL areset_next_word2 got %h last=%b want 00000120 last=1", d, l); end
    n_cmp++; if (rec_count !== 32'd1 || match_count !== 32'd0) begin n_err++; $display("FAIL areset_next_counts got %0d/%0d want 1/0", rec_count, match_count); end
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_boundary_drop();
    test_backpressure();
    test_sparse();
    test_clear_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
